// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first,
// repeat_cnt+1 times, with gap_len idle cycles between frames.
module seq_pattern_tx #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             d_out,
  output logic             valid_out,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [PAT_W-1:0]   shreg, shreg_n;
  logic [PAT_W-1:0]   pat_q, pat_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [CNT_W-1:0]   frame_cnt, frame_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [GAP_W-1:0]   gap_reload, gap_reload_n;

  // Outputs are registered from the next-state values so they stay Moore-timed.
  logic d_out_n, valid_out_n, frame_start_n, busy_n, done_n;

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shreg       <= '0;
      pat_q       <= '0;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      gap_cnt     <= '0;
      gap_reload  <= '0;
      d_out       <= 1'b0;
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      pat_q       <= pat_n;
      bit_cnt     <= bit_cnt_n;
      frame_cnt   <= frame_cnt_n;
      gap_cnt     <= gap_cnt_n;
      gap_reload  <= gap_reload_n;
      d_out       <= d_out_n;
      valid_out   <= valid_out_n;
      frame_start <= frame_start_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Next-state, datapath update and next-output decode.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    pat_n        = pat_q;
    bit_cnt_n    = bit_cnt;
    frame_cnt_n  = frame_cnt;
    gap_cnt_n    = gap_cnt;
    gap_reload_n = gap_reload;

    unique case (state)
      IDLE: begin
        if (start) begin
          pat_n        = pattern;
          shreg_n      = pattern;
          frame_cnt_n  = repeat_cnt;
          gap_reload_n = gap_len;
          bit_cnt_n    = '0;
          gap_cnt_n    = '0;
          state_n      = SHIFT;
        end
      end
      SHIFT: begin
        shreg_n = shreg << 1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_n = '0;
          if (frame_cnt == '0) begin
            state_n = DONE;
          end else begin
            frame_cnt_n = frame_cnt - CNT_W'(1);
            if (gap_reload == '0) begin
              // Back-to-back frames: reload with no bubble.
              shreg_n = pat_q;
            end else begin
              gap_cnt_n = gap_reload;
              state_n   = GAP;
            end
          end
        end else begin
          bit_cnt_n = bit_cnt + BIT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          gap_cnt_n = '0;
          shreg_n   = pat_q;
          state_n   = SHIFT;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      DONE: begin
        shreg_n     = '0;
        bit_cnt_n   = '0;
        frame_cnt_n = '0;
        gap_cnt_n   = '0;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Abort overrides every transition, including a start in IDLE.
    if (abort) begin
      state_n     = IDLE;
      shreg_n     = '0;
      bit_cnt_n   = '0;
      frame_cnt_n = '0;
      gap_cnt_n   = '0;
    end

    d_out_n       = (state_n == SHIFT) && shreg_n[PAT_W-1];
    valid_out_n   = (state_n == SHIFT);
    frame_start_n = (state_n == SHIFT) && (bit_cnt_n == '0);
    busy_n        = (state_n != IDLE);
    done_n        = (state_n == DONE);
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx against a frame-level stream model.
module tb_seq_pattern_tx;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             start2 = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [1:0]       pattern2 = '0;
  logic [CNT_W-1:0] repeat_cnt = '0;
  logic [GAP_W-1:0] gap_len = '0;

  logic d_out, valid_out, frame_start, busy, done;
  logic d_out2, valid_out2, frame_start2, busy2, done2;
  logic [4:0] obs, obs2;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Expected per-cycle {d_out, valid_out, frame_start, busy, done}.
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  assign obs  = {d_out, valid_out, frame_start, busy, done};
  assign obs2 = {d_out2, valid_out2, frame_start2, busy2, done2};

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .d_out      (d_out),
    .valid_out  (valid_out),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  seq_pattern_tx #(.PAT_W(2), .CNT_W(CNT_W), .GAP_W(GAP_W)) u_dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start2),
    .abort      (abort),
    .pattern    (pattern2),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .d_out      (d_out2),
    .valid_out  (valid_out2),
    .frame_start(frame_start2),
    .busy       (busy2),
    .done       (done2)
  );

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (d,v,fs,busy,done)", tag, got, want);
    end
  endtask

  // Expected stream: frames of MSB-first bits, gaps between frames, done, idle.
  task automatic build(input logic [PAT_W-1:0] pat, input int rep, input int gap);
    exp_q.delete();
    for (int f = 0; f <= rep; f++) begin
      for (int i = 0; i < int'(PAT_W); i++)
        exp_q.push_back({pat[PAT_W-1-i], 1'b1, (i == 0), 1'b1, 1'b0});
      if (f < rep)
        for (int g = 0; g < gap; g++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00011);
    exp_q.push_back(5'b00000);
  endtask

  // Start one transmission now (DUT idle, #1 after an edge) and check every cycle.
  task automatic run_tx(input string tag, input logic [PAT_W-1:0] pat, input int rep,
                        input int gap, input int abort_at, input bit noise);
    bit aborted = 1'b0;
    pattern    = pat;
    repeat_cnt = CNT_W'(rep);
    gap_len    = GAP_W'(gap);
    start      = 1'b1;
    build(pat, rep, gap);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (aborted) begin
        check($sformatf("%s post-abort c%0d", tag, c), obs, 5'b00000);
        break;
      end
      check($sformatf("%s c%0d", tag, c), obs, exp_q[c-1]);
      if (c == abort_at) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
      if (noise && exp_q[c-1][1]) begin
        start      = 1'($urandom);
        pattern    = PAT_W'($urandom);
        repeat_cnt = CNT_W'($urandom);
        gap_len    = GAP_W'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #12;
    check("reset state", obs, 5'b00000);
    check("reset state w2", obs2, 5'b00000);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", obs, 5'b00000);

    run_tx("single", 4'b1010, 0, 0, 0, 1'b0);
    run_tx("contig", 4'b1010, 2, 0, 0, 1'b0);
    run_tx("gap2", 4'b1010, 1, 2, 0, 1'b0);
    run_tx("noise", 4'b1010, 1, 1, 0, 1'b1);
    run_tx("abort3", 4'b1010, 3, 0, 3, 1'b0);
    run_tx("restart", 4'b1010, 0, 0, 0, 1'b0);
    run_tx("maxrep", 4'b1001, 15, 0, 0, 1'b0);
    run_tx("maxgap", 4'b0110, 1, 15, 0, 1'b0);

    // abort and start together in IDLE: nothing starts
    pattern = 4'b1111; repeat_cnt = '0; gap_len = '0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort+start idle", obs, 5'b00000);
    @(posedge clk); #1;
    check("abort+start idle2", obs, 5'b00000);

    // Randomized transactions, some aborted, some with input noise.
    for (int t = 0; t < 40; t++) begin
      logic [PAT_W-1:0] p;
      int r, g, len, ab;
      p = PAT_W'($urandom);
      r = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
      g = int'($urandom_range(0, 3));
      len = (r + 1) * int'(PAT_W) + r * g + 1;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, len)) : 0;
      run_tx($sformatf("rnd%0d", t), p, r, g, ab, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
        check($sformatf("rnd%0d idle", t), obs, 5'b00000);
      end
    end

    // Asynchronous reset in the middle of a gap.
    pattern = 4'b1010; repeat_cnt = CNT_W'(1); gap_len = GAP_W'(3);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre-reset gap", obs, 5'b00010);
    reset_n = 1'b0;
    #1;
    check("async reset", obs, 5'b00000);
    #2;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset idle %0d", c), obs, 5'b00000);
    end

    // Two-bit pattern variant: 1,1 then done.
    pattern2 = 2'b11; repeat_cnt = '0; gap_len = '0;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("w2 bit0", obs2, 5'b11110);
    @(posedge clk); #1;
    check("w2 bit1", obs2, 5'b11010);
    @(posedge clk); #1;
    check("w2 done", obs2, 5'b00011);
    @(posedge clk); #1;
    check("w2 idle", obs2, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter. Emits a programmable PAT_W-bit pattern MSB-first, one bit per clk, repeated a programmable number of times with an optional idle gap between frames.
- Source side of the serial sequence-detection path. Drives d_out into the sequence detector FSMs. Default pattern 4'b1010.
- Moore-style: all outputs decode from registered state and datapath only; no combinational input-to-output path.

Parameters:
PAT_W, 4, pattern width in bits (>=2)
CNT_W, 4, width of repeat count
GAP_W, 4, width of inter-frame gap length

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request transmission; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE next edge
pattern  input  PAT_W  pattern to send, MSB first
repeat_cnt  input  CNT_W  extra frames; frames sent = repeat_cnt+1
gap_len  input  GAP_W  idle cycles between frames (0 = back-to-back)
d_out  output  1  serial data bit
valid_out  output  1  d_out carries a pattern bit
frame_start  output  1  high during first bit of each frame
busy  output  1  transmission in progress (SHIFT, GAP, DONE)
done  output  1  one-cycle pulse after last bit of last frame

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset state: IDLE, with d_out=0, valid_out=0, frame_start=0, busy=0, done=0. Shift register, bit counter, frame counter and gap counter all clear to 0.
- States (binary encoded): IDLE, SHIFT, GAP, DONE.
- IDLE:
  - Outputs all 0.
  - start=1 at an edge: captures pattern into the shift register, repeat_cnt into the frame counter, gap_len into the gap-reload register, then enters SHIFT.
  - Latency: first bit (pattern[PAT_W-1]) is visible in the cycle after the start edge.
- SHIFT:
  - d_out = shreg[PAT_W-1]; valid_out=1; busy=1.
  - frame_start=1 when bit counter is 0.
  - Each edge: shift left by one and increment the bit counter.
  - After bit PAT_W-1 of a frame:
    - frame counter == 0 -> DONE.
    - else, gap_len == 0 -> reload shreg from the captured pattern, decrement frame counter, stay in SHIFT (contiguous bits, no bubble).
    - else -> GAP with gap counter = gap_len, decrement frame counter.
- GAP:
  - d_out=0, valid_out=0, busy=1.
  - Decrement gap counter each edge; after exactly gap_len cycles, reload shreg and enter SHIFT.
- DONE:
  - One cycle: done=1, busy=1, valid_out=0, d_out=0; then IDLE.
  - A start during DONE is ignored. A new start is accepted at the earliest in the following IDLE cycle.
- Input capture:
  - start while not in IDLE is ignored.
  - pattern, repeat_cnt and gap_len changes after capture have no effect on the transmission in progress.
- abort:
  - Highest priority over all transitions (below reset). Any state -> IDLE on the next edge.
  - No done pulse; counters cleared.
  - abort and start in the same IDLE cycle: abort wins, nothing starts.
- Reset mid-operation: outputs drop to reset values immediately (asynchronous); no done pulse.
- Counter widths:
  - Bit counter is clog2(PAT_W) bits, wraps to 0 at frame end.
  - repeat_cnt = all-ones sends 2^CNT_W frames; no overflow.
- Total cycles from start edge to done pulse, inclusive: (repeat_cnt+1)*PAT_W + repeat_cnt*gap_len + 1.

Test Plan:
- pattern=1010, repeat_cnt=0, gap_len=0, start at cycle 0 -> d_out 1,0,1,0 on cycles 1-4 with valid_out=1; frame_start only cycle 1; done=1 cycle 5; busy cycles 1-5; IDLE cycle 6.
- pattern=1010, repeat_cnt=2, gap_len=0 -> 101010101010 contiguous, cycles 1-12; frame_start at cycles 1, 5, 9; done cycle 13; downstream 1010 detector output asserts after each frame.
- pattern=1010, repeat_cnt=1, gap_len=2 -> 1010 on cycles 1-4; cycles 5-6 valid_out=0, d_out=0; 1010 on cycles 7-10; done cycle 11.
- start pulsed at cycle 2 during a transmission, and pattern changed to 1111 at cycle 2 -> stream unchanged; exactly one done pulse.
- abort at cycle 3 of a repeat_cnt=3 run -> IDLE at cycle 4, all outputs 0, no done pulse; a new start at cycle 5 transmits normally.
- reset_n low mid-GAP -> outputs 0 asynchronously; after release, IDLE and no done pulse; pattern=11, PAT_W=2 run yields 1,1 then done.
